// File: rtl/crc_arb_seq.sv
// ---------------------------------------------------------------------------
// crc_arb_seq
//
// Two-requester round-robin front end feeding a bit-serial CRC-4 engine.
// A requester hands over a 32-bit message. The engine shifts the message
// through the CRC register MSB first, one bit per clock. It then presents
// the codeword {message, crc} downstream with a valid/ready handshake.
//
// Parameters:
//   POLY       low 4 coefficients of the CRC-4 generator (x^4 implied);
//              the default 4'b0011 is x^4 + x + 1.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst_n      asynchronous, active-low reset
//   req_valid  per-requester message valid (bit i = requester i)
//   req_ready  per-requester accept, one-hot to the arbiter winner in IDLE
//   req_data0  requester 0 message
//   req_data1  requester 1 message
//   out_valid  codeword valid (registered)
//   out_ready  downstream accept
//   d_out      codeword {message[31:0], crc[3:0]}, zero outside OUT
//   out_src    index of the requester that supplied the codeword
//   busy       high whenever the sequencer is not idle (registered)
// ---------------------------------------------------------------------------
module crc_arb_seq #(
  parameter logic [3:0] POLY = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] d_out,
  output logic        out_src,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] msg;
  logic        src;
  logic [3:0]  crc;
  logic [3:0]  crc_next;
  logic [4:0]  cnt;
  logic        prio;
  logic        accept;
  logic        grant_idx;
  logic        fb;

  // Arbiter: only offers a grant while idle and out of reset. A lone
  // requester always wins. When both are asking, prio names the requester
  // that was not granted last, so the two alternate.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state == S_IDLE)) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = prio ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign grant_idx = req_ready[1];

  // One step of the serial CRC. The message bit selected by the down-counter
  // is combined with the register MSB to decide whether the generator is
  // folded in. This gives M(x)*x^4 mod G(x) with a zero seed and no
  // final XOR.
  always_comb begin
    fb       = crc[3] ^ msg[cnt];
    crc_next = {crc[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);
  end

  // Next-state decode. It is kept separate so that out_valid and busy can
  // be registered straight from it. That keeps both flops glitch-free and
  // independent of out_ready within the cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CALC;
      S_CALC:  if (cnt == 5'd0) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer and datapath registers. An accept captures the message and
  // its source, clears the CRC and loads the counter with the MSB index.
  // CALC then walks the counter down to zero, one bit per clock. Reset
  // throws away anything in flight, and the pointer goes back to
  // favouring requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      msg       <= 32'h0;
      src       <= 1'b0;
      crc       <= 4'h0;
      cnt       <= 5'd0;
      prio      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next == S_OUT);
      busy      <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            msg  <= grant_idx ? req_data1 : req_data0;
            src  <= grant_idx;
            crc  <= 4'h0;
            cnt  <= 5'd31;
            prio <= ~grant_idx;
          end
        end
        S_CALC: begin
          crc <= crc_next;
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The codeword and its source only show while a result is being offered.
  // At all other times they read as zero.
  always_comb begin
    d_out   = 36'h0;
    out_src = 1'b0;
    if (out_valid) begin
      d_out   = {msg, crc};
      out_src = src;
    end
  end

endmodule

// File: tb/tb_crc_arb_seq.sv
// ---------------------------------------------------------------------------
// tb_crc_arb_seq
//
// Directed bench for crc_arb_seq. The expected codewords were worked out
// by hand as remainders of M(x)*x^4 mod x^4+x+1. Inputs are driven on the
// falling edge, and outputs are sampled there or shortly after.
// ---------------------------------------------------------------------------
module tb_crc_arb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] d_out;
  logic        out_src;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  crc_arb_seq #(.POLY(4'b0011)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .out_src   (out_src),
    .busy      (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive all requester/downstream inputs at once
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0,
                               input logic [31:0] d1, input logic ordy);
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    out_ready = ordy;
  endtask

  // Pulse reset for a few cycles, releasing it on a falling edge
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one message from a single requester and follow it to the codeword.
  // The source data is scrambled during CALC to show the latched copy is used.
  task automatic runOne(input int which, input logic [31:0] data,
                        input logic [35:0] exp_word);
    int n;
    logic [1:0] vbit;
    vbit = (which == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    applyStimulus(vbit, (which == 0) ? data : 32'h0,
                  (which == 1) ? data : 32'h0, 1'b1);
    #1 checkOutput("ready_onehot", 64'(req_ready), 64'(vbit));
    @(posedge clk);
    @(negedge clk);
    applyStimulus(2'b00, ~data, ~data, 1'b1);
    checkOutput("busy_calc", 64'(busy), 64'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency_edges", 64'(n), 64'd32);
    checkOutput("d_out", 64'(d_out), 64'(exp_word));
    checkOutput("out_src", 64'(out_src), 64'(which));
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_d_out", 64'(d_out), 64'd0);
  endtask

  initial begin
    logic        grant_hist [4];
    int          accept_t   [4];
    int          grant_cnt;
    int          n;

    // Reset state, with both requesters asking so req_ready gating is visible
    rst_n = 1'b0;
    applyStimulus(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_d_out", 64'(d_out), 64'd0);
    checkOutput("rst_out_src", 64'(out_src), 64'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    rst_n = 1'b1;

    // Single-requester messages with hand-computed CRCs
    runOne(0, 32'hFFFFFFFF, 36'hFFFFFFFF5);
    runOne(1, 32'h00000000, 36'h000000000);
    runOne(0, 32'h12345678, 36'h123456786);
    // Pointer now favours 1, but a lone requester 0 must still win
    runOne(0, 32'h00000001, 36'h000000013);
    runOne(1, 32'h80000000, 36'h800000006);

    // Both requesters valid from reset: grants alternate, 34-cycle spacing
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    doReset();
    grant_cnt = 0;
    for (int t = 0; t < 200 && grant_cnt < 4; t++) begin
      #1;
      if (out_valid === 1'b1 && grant_cnt > 0)
        checkOutput("rr_d_out", 64'(d_out),
                    grant_hist[grant_cnt-1] ? 64'h123456786 : 64'hFFFFFFFF5);
      if (req_ready != 2'b00) begin
        grant_hist[grant_cnt] = req_ready[1];
        accept_t[grant_cnt]   = t;
        grant_cnt++;
      end
      @(negedge clk);
    end
    checkOutput("rr_grant_count", 64'(grant_cnt), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_cnt)
        checkOutput("rr_grant_seq", 64'(grant_hist[i]), 64'(i % 2));
    for (int i = 0; i < 3; i++)
      if (i + 1 < grant_cnt)
        checkOutput("rr_spacing", 64'(accept_t[i+1] - accept_t[i]), 64'd34);

    // Downstream stall: codeword must hold while out_ready is low
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
    doReset();
    @(negedge clk);
    applyStimulus(2'b01, 32'h12345678, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_reach_out", 64'(n), 64'd32);
    applyStimulus(2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_d_out", 64'(d_out), 64'h123456786);
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("stall_release_busy", 64'(busy), 64'd0);
    checkOutput("stall_release_valid", 64'(out_valid), 64'd0);

    // Reset mid-CALC after a requester-0 grant: outputs clear at once,
    // nothing is emitted, and the pointer favours requester 0 again
    @(negedge clk);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(2'b11, 32'h0, 32'h0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("midcalc_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midcalc_rst_busy", 64'(busy), 64'd0);
    checkOutput("midcalc_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("midcalc_rst_d_out", 64'(d_out), 64'd0);
    checkOutput("midcalc_rst_ready", 64'(req_ready), 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("midcalc_no_codeword", 64'(out_valid), 64'd0);
    applyStimulus(2'b11, 32'h00000001, 32'h80000000, 1'b1);
    rst_n = 1'b1;
    #1 checkOutput("midcalc_regrant", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midcalc_latency", 64'(n), 64'd32);
    checkOutput("midcalc_d_out", 64'(d_out), 64'h000000013);
    checkOutput("midcalc_out_src", 64'(out_src), 64'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
